// File: rtl/riscv_mem_pkg.sv
// Shared constants for the data-RAM arbiter: lock FSM states, owner tags and default widths.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-input picker: single requester wins; on contention either M0 (fixed priority)
// or the master that was not granted last.
module arb_rr2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives gnt_o and no latch is inferred.
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || fixed_prio_i || last_i == OWN_M1)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port data RAM between the core LSU (M0) and the loader/debug port (M1),
// with an M1 bus lock bounded by a watchdog that counts cycles M0 is kept waiting.
module dram_arbiter
  import riscv_mem_pkg::*;
#(
  parameter  int ADDR_W     = DEF_ADDR_W,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int FIXED_PRIO = 0,
  parameter  int LOCK_MAX   = 64,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_strb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_strb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WDOG_W = $clog2(LOCK_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(LOCK_MAX);

  arb_state_e        state_q;
  logic              last_q;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              rd_pend_q;
  logic              rd_own_q;

  logic [1:0]        arb_req;
  logic [1:0]        gnt;
  logic              sel_we;
  logic [STRB_W-1:0] sel_strb;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // While locked M0 is masked out; reset masks everyone so no grant leaks out.
  assign arb_req = {m1_req & ~reset, m0_req & ~reset & (state_q == ARB)};

  arb_rr2 u_arb (
    .req_i       (arb_req),
    .last_i      (last_q),
    .fixed_prio_i(FIXED_PRIO != 0),
    .gnt_o       (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    sel_we    = gnt[1] ? m1_we    : m0_we;
    sel_strb  = gnt[1] ? m1_strb  : m0_strb;
    sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
    ram_en    = |gnt;
    ram_we    = (ram_en && sel_we) ? sel_strb : '0;
    ram_addr  = ram_en ? sel_addr  : '0;
    ram_wdata = ram_en ? sel_wdata : '0;
  end

  // Saturating count of cycles M0 spends waiting behind a lock.
  assign wdog_d = (m0_req && wdog_q != WDOG_MAX) ? wdog_q + 1'b1 : wdog_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      last_q    <= OWN_M1;
      wdog_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_own_q  <= OWN_M0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (|gnt) begin
        last_q <= gnt[1] ? OWN_M1 : OWN_M0;
      end
      rd_pend_q <= ram_en && !sel_we;
      rd_own_q  <= gnt[1] ? OWN_M1 : OWN_M0;
      case (state_q)
        ARB: begin
          wdog_q <= '0;
          if (gnt[1] && m1_lock) begin
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (!m1_req || !m1_lock || wdog_d == WDOG_MAX) begin
            state_q <= ARB;
            wdog_q  <= '0;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  // A read issued just before reset must not surface while reset is held.
  assign m0_rvalid = rd_pend_q && (rd_own_q == OWN_M0) && !reset;
  assign m1_rvalid = rd_pend_q && (rd_own_q == OWN_M1) && !reset;
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule
